// File: rtl/fifo_pkg.sv
// Shared token helpers for the multi-flux FIFO
// and the dataflow actors that talk to it.
package fifo_pkg;

  localparam int DEF_FLUX       = 2;
  localparam int DEF_DATA_WIDTH = 8;

  function automatic int tag_width(input int flux);
    return (flux <= 2) ? 1 : $clog2(flux);
  endfunction

  localparam int DEF_TAG_WIDTH = tag_width(DEF_FLUX);

  typedef struct packed {
    logic [DEF_TAG_WIDTH-1:0]  tag;
    logic [DEF_DATA_WIDTH-1:0] data;
  } token_t;

  function automatic token_t pack_token(
    input logic [DEF_TAG_WIDTH-1:0]  tag,
    input logic [DEF_DATA_WIDTH-1:0] data
  );
    token_t t;
    t.tag  = tag;
    t.data = data;
    return t;
  endfunction

endpackage

// File: rtl/read_interface.sv
// Consumer side of the tagged FIFO link.
// The fifo modport serves per-flux pops and reports empty.
interface read_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 9
);
  logic [FLUX-1:0]  read;
  logic [WIDTH-1:0] dout;
  logic [FLUX-1:0]  empty;

  modport fifo  (input read, output dout, output empty);
  modport actor (output read, input dout, input empty);
endinterface

// File: rtl/write_interface.sv
// Producer side of the tagged FIFO link.
// The fifo modport receives tokens and reports per-flux full.
interface write_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 9
);
  logic             write;
  logic [WIDTH-1:0] din;
  logic [FLUX-1:0]  full;

  modport fifo  (input write, input din, output full);
  modport actor (output write, output din, input full);
endinterface

// File: rtl/flux_queue.sv
// One circular buffer; guards its own push/pop
// against full/empty using the registered count.
module flux_queue #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_q];

  // next pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // pointer/count state, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // token storage, not reset
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/tagged_flux_fifo.sv
// Tag-steered multi-flux FIFO: decodes the write tag,
// picks the served flux and muxes its head onto dout.
module tagged_flux_fifo
  import fifo_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input logic          clk,
  input logic          rst,
  write_interface.fifo write_port,
  read_interface.fifo  read_port
);

  localparam int TAG_WIDTH = tag_width(FLUX);
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;

  logic [TAG_WIDTH-1:0]  wtag;
  logic [DATA_WIDTH-1:0] wdata;
  logic [FLUX-1:0]       push;
  logic [FLUX-1:0]       pop;
  logic [FLUX-1:0]       empty_w;
  logic [FLUX-1:0]       full_w;
  logic [DATA_WIDTH-1:0] head [FLUX];

  logic                  rd_hit;
  logic [TAG_WIDTH-1:0]  rd_idx;
  logic                  ne_hit;
  logic [TAG_WIDTH-1:0]  ne_idx;
  logic [TAG_WIDTH-1:0]  sel;
  logic [DATA_WIDTH-1:0] sel_data;

  assign wtag  = write_port.din[WIDTH-1 -: TAG_WIDTH];
  assign wdata = write_port.din[DATA_WIDTH-1:0];

  // tag decode; tags with no matching flux push nothing
  always_comb begin
    push = '0;
    for (int i = 0; i < FLUX; i++) begin
      push[i] = write_port.write &&
                (wtag == TAG_WIDTH'(i));
    end
  end

  // lowest read bit wins; idle dout shows lowest non-empty flux
  always_comb begin
    rd_hit = 1'b0;
    rd_idx = '0;
    ne_hit = 1'b0;
    ne_idx = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (read_port.read[i] && !rd_hit) begin
        rd_hit = 1'b1;
        rd_idx = TAG_WIDTH'(i);
      end
      if (!empty_w[i] && !ne_hit) begin
        ne_hit = 1'b1;
        ne_idx = TAG_WIDTH'(i);
      end
    end
    sel = rd_hit ? rd_idx : (ne_hit ? ne_idx : '0);
  end

  // one-hot pop of the honoured read bit and dout data mux
  always_comb begin
    pop      = '0;
    sel_data = head[0];
    for (int i = 0; i < FLUX; i++) begin
      pop[i] = rd_hit && (rd_idx == TAG_WIDTH'(i));
      if (sel == TAG_WIDTH'(i)) begin
        sel_data = head[i];
      end
    end
  end

  for (genvar g = 0; g < FLUX; g++) begin : g_q
    flux_queue #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_q (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata (wdata),
      .head  (head[g]),
      .empty (empty_w[g]),
      .full  (full_w[g])
    );
  end

  assign write_port.full = full_w;
  assign read_port.empty = empty_w;
  assign read_port.dout  = {sel, sel_data};

endmodule

// File: tb/tb_tagged_flux_fifo.sv
// Directed bench for tagged_flux_fifo with
// FLUX=2, DATA_WIDTH=8, DEPTH=16.
module tb_tagged_flux_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  write_interface #(.FLUX(2), .WIDTH(9)) wif ();
  read_interface  #(.FLUX(2), .WIDTH(9)) rif ();

  tagged_flux_fifo #(
    .FLUX       (2),
    .DATA_WIDTH (8),
    .DEPTH      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .write_port (wif),
    .read_port  (rif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wif.write = 1'b0;
    wif.din   = '0;
    rif.read  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rif.empty !== 2'b11) begin
      errors++;
      $display("FAIL reset_empty got=%b exp=11", rif.empty);
    end
    checks++;
    if (wif.full !== 2'b00) begin
      errors++;
      $display("FAIL reset_full got=%b exp=00", wif.full);
    end
    checks++;
    if (rif.dout[8] !== 1'b0) begin
      errors++;
      $display("FAIL reset_tag got=%b exp=0", rif.dout[8]);
    end
    repeat (5) tick();
    checks++;
    if (rif.empty !== 2'b11 || wif.full !== 2'b00) begin
      errors++;
      $display("FAIL idle_flags got=%b/%b exp=11/00",
               rif.empty, wif.full);
    end
  endtask

  task automatic test_order();
    wif.write = 1'b1;
    wif.din   = 9'h0A1;
    tick();
    checks++;
    if (rif.empty !== 2'b10) begin
      errors++;
      $display("FAIL wr_latency got=%b exp=10", rif.empty);
    end
    wif.din = 9'h1B2;
    tick();
    wif.din = 9'h0A3;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rif.empty !== 2'b00) begin
      errors++;
      $display("FAIL order_fill got=%b exp=00", rif.empty);
    end
    rif.read = 2'b01;
    #1;
    checks++;
    if (rif.dout !== 9'h0A1) begin
      errors++;
      $display("FAIL order_a1 got=%h exp=0a1", rif.dout);
    end
    tick();
    checks++;
    if (rif.dout !== 9'h0A3) begin
      errors++;
      $display("FAIL order_a3 got=%h exp=0a3", rif.dout);
    end
    tick();
    rif.read = 2'b10;
    #1;
    checks++;
    if (rif.dout !== 9'h1B2) begin
      errors++;
      $display("FAIL order_b2 got=%h exp=1b2", rif.dout);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rif.empty !== 2'b11) begin
      errors++;
      $display("FAIL order_drain got=%b exp=11", rif.empty);
    end
  endtask

  task automatic test_full_wrap();
    wif.write = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wif.din = {1'b1, 8'(k)};
      tick();
      if (k == 14) begin
        checks++;
        if (wif.full !== 2'b00) begin
          errors++;
          $display("FAIL full_early got=%b exp=00", wif.full);
        end
      end
    end
    checks++;
    if (wif.full !== 2'b10) begin
      errors++;
      $display("FAIL full_set got=%b exp=10", wif.full);
    end
    wif.din = 9'h1FF;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (wif.full !== 2'b10) begin
      errors++;
      $display("FAIL full_hold got=%b exp=10", wif.full);
    end
    rif.read = 2'b10;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (rif.dout !== {1'b1, 8'(k)}) begin
        errors++;
        $display("FAIL wrap_rd%0d got=%h exp=%h",
                 k, rif.dout, {1'b1, 8'(k)});
      end
      tick();
      if (k == 0) begin
        checks++;
        if (wif.full !== 2'b00) begin
          errors++;
          $display("FAIL full_clear got=%b exp=00", wif.full);
        end
      end
    end
    idle_inputs();
    #1;
    checks++;
    if (rif.empty !== 2'b11) begin
      errors++;
      $display("FAIL wrap_drop got=%b exp=11", rif.empty);
    end
  endtask

  task automatic test_empty_simul();
    wif.write = 1'b1;
    wif.din   = 9'h055;
    rif.read  = 2'b01;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rif.empty !== 2'b10) begin
      errors++;
      $display("FAIL es_empty got=%b exp=10", rif.empty);
    end
    checks++;
    if (rif.dout !== 9'h055) begin
      errors++;
      $display("FAIL es_dout got=%h exp=055", rif.dout);
    end
    rif.read = 2'b01;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rif.empty !== 2'b11) begin
      errors++;
      $display("FAIL es_drain got=%b exp=11", rif.empty);
    end
  endtask

  task automatic test_full_simul();
    wif.write = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wif.din = {1'b0, 8'(8'h10 + k)};
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (wif.full !== 2'b01) begin
      errors++;
      $display("FAIL fs_full got=%b exp=01", wif.full);
    end
    wif.write = 1'b1;
    wif.din   = 9'h077;
    rif.read  = 2'b01;
    #1;
    checks++;
    if (rif.dout !== 9'h010) begin
      errors++;
      $display("FAIL fs_head got=%h exp=010", rif.dout);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (wif.full !== 2'b00 || rif.empty !== 2'b10) begin
      errors++;
      $display("FAIL fs_flags got=%b/%b exp=00/10",
               wif.full, rif.empty);
    end
    rif.read = 2'b01;
    for (int k = 1; k < 16; k++) begin
      #1;
      checks++;
      if (rif.dout !== {1'b0, 8'(8'h10 + k)}) begin
        errors++;
        $display("FAIL fs_rd%0d got=%h exp=%h",
                 k, rif.dout, {1'b0, 8'(8'h10 + k)});
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (rif.empty !== 2'b11) begin
      errors++;
      $display("FAIL fs_count got=%b exp=11", rif.empty);
    end
  endtask

  task automatic test_priority_reset();
    wif.write = 1'b1;
    wif.din   = 9'h0C0;
    tick();
    wif.din = 9'h1D1;
    tick();
    idle_inputs();
    rif.read = 2'b11;
    #1;
    checks++;
    if (rif.dout !== 9'h0C0) begin
      errors++;
      $display("FAIL pri_dout got=%h exp=0c0", rif.dout);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rif.empty !== 2'b01) begin
      errors++;
      $display("FAIL pri_empty got=%b exp=01", rif.empty);
    end
    checks++;
    if (rif.dout !== 9'h1D1) begin
      errors++;
      $display("FAIL pri_idle got=%h exp=1d1", rif.dout);
    end
    wif.write = 1'b1;
    wif.din   = 9'h0E0;
    rif.read  = 2'b10;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (rif.empty !== 2'b11 || wif.full !== 2'b00) begin
      errors++;
      $display("FAIL mid_rst got=%b/%b exp=11/00",
               rif.empty, wif.full);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_order();
    test_full_wrap();
    test_empty_simul();
    test_full_simul();
    test_priority_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
